// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one recoded multiplier digit per clock,
// with a start/busy/done handshake so one instance can be time-shared.
module booth_mult_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   md,
  input  logic [N-1:0]   mr,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           booth_add,
  output logic           booth_sub
);

  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [N:0]    m, a, a_nxt, a_sh;
  logic [N-1:0]  q, q_sh;
  logic          q_1;
  logic [CW-1:0] cnt;

  // A is one bit wider than the operands so md = -2^(N-1) cannot overflow.
  always_comb begin
    a_nxt = a;
    case ({q[0], q_1})
      2'b01:   a_nxt = a + m;
      2'b10:   a_nxt = a - m;
      default: a_nxt = a;
    endcase
    a_sh = {a_nxt[N], a_nxt[N:1]};
    q_sh = {a_nxt[0], q[N-1:1]};
  end

  assign booth_add = (state == RUN) && ({q[0], q_1} == 2'b01);
  assign booth_sub = (state == RUN) && ({q[0], q_1} == 2'b10);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {md[N-1], md};
            a     <= '0;
            q     <= mr;
            q_1   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a   <= a_sh;
          q   <= q_sh;
          q_1 <= q[0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= {a_sh[N-1:0], q_sh};
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (N=4): directed cases, full operand
// sweep, abort/ignore scenarios and continuous-start throughput.
module tb_booth_mult_seq;
  localparam int N = 4;
  localparam int P = N + 2;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [N-1:0]   md, mr;
  logic           busy, done, booth_add, booth_sub;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .md(md), .mr(mr),
    .busy(busy), .done(done), .product(product),
    .booth_add(booth_add), .booth_sub(booth_sub)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed reference product, truncated to 2N bits.
  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*N-1:0];
  endfunction

  // Booth digit i of the multiplier: pair (mr[i], mr[i-1]) with mr[-1]=0.
  function automatic logic [1:0] ref_digit(input logic [N-1:0] b, input int i);
    logic prev;
    prev = (i == 0) ? 1'b0 : b[i-1];
    return {(!b[i] && prev), (b[i] && !prev)};  // {add, sub}
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    md = a; mr = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk({tag, " busy_run"}, 16'(busy), 16'd1);
      chk({tag, " done_run"}, 16'(done), 16'd0);
      chk({tag, " digit"}, 16'({booth_add, booth_sub}), 16'(ref_digit(b, i)));
      tick();
    end
    chk({tag, " done"}, 16'(done), 16'd1);
    chk({tag, " product"}, 16'(product), 16'(ref_prod(a, b)));
    chk({tag, " digit_done"}, 16'({booth_add, booth_sub}), 16'd0);
    tick();
    chk({tag, " done_fall"}, 16'(done), 16'd0);
    chk({tag, " busy_fall"}, 16'(busy), 16'd0);
    chk({tag, " product_hold"}, 16'(product), 16'(ref_prod(a, b)));
  endtask

  initial begin
    logic [N-1:0] qa [0:63];
    logic [N-1:0] qb [0:63];
    int dones;
    rst = 1'b1; start = 1'b0; md = '0; mr = '0;
    tick(); tick();
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst product", 16'(product), 16'd0);
    chk("rst digit", 16'({booth_add, booth_sub}), 16'd0);
    rst = 1'b0;
    tick();

    // Directed cases.
    run_op(4'd3, 4'd5, "3x5");
    chk("3x5 const", 16'(product), 16'h0F);
    run_op(4'hD, 4'd5, "-3x5");
    chk("-3x5 const", 16'(product), 16'hF1);
    run_op(4'd7, 4'h8, "7x-8");
    chk("7x-8 const", 16'(product), 16'hC8);
    run_op(4'h8, 4'h8, "-8x-8");
    chk("-8x-8 const", 16'(product), 16'h40);

    // Full sweep of every operand pair.
    for (int i = 0; i < 256; i++) run_op(4'(i >> 4), 4'(i), "sweep");

    // Start during RUN is ignored: one done pulse, original product.
    md = 4'd6; mr = 4'hB; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    md = 4'd1; mr = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 3 * P; c++) begin
      if (done) begin
        dones++;
        chk("ignore product", 16'(product), 16'(ref_prod(4'd6, 4'hB)));
      end
      tick();
    end
    chk("ignore done_count", 16'(dones), 16'd1);

    // Reset two edges after acceptance aborts the operation.
    md = 4'd5; mr = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort product", 16'(product), 16'd0);
    dones = 0;
    for (int c = 0; c < 2 * P; c++) begin
      if (done) dones++;
      tick();
    end
    chk("abort no_done", 16'(dones), 16'd0);
    chk("abort product_held", 16'(product), 16'd0);
    run_op(4'd5, 4'd7, "post_abort");

    // Reset and start on the same edge: reset wins.
    rst = 1'b1; start = 1'b1; md = 4'd2; mr = 4'd3;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", 16'(busy), 16'd0);
    tick();
    chk("rst_start busy2", 16'(busy), 16'd0);

    // Random operands with start held high: accepts every N+2 edges.
    start = 1'b1;
    dones = 0;
    for (int c = 0; c < 8 * P; c++) begin
      md = 4'($urandom_range(0, 15));
      mr = 4'($urandom_range(0, 15));
      qa[c % 64] = md; qb[c % 64] = mr;
      tick();
      chk("hold done", 16'(done), 16'((c % P) == N));
      if ((c % P) == N) begin
        dones++;
        chk("hold product", 16'(product), 16'(ref_prod(qa[(c - N) % 64], qb[(c - N) % 64])));
      end
    end
    start = 1'b0;
    chk("hold done_count", 16'(dones), 16'd8);

    // Random single operations.
    for (int i = 0; i < 20; i++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
